tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-slot time-division demultiplexer. It is the receive end of a serial link whose transmit side selects one of four data bits per slot with a 4->1 mux. It takes the serialized bit stream plus a frame-sync marker and tracks the slot index. It steers each bit into its slot register and presents the reassembled 4-bit frame on `d0..d3` with a one-cycle `valid` strobe.

## Interface
- `REQ_SYNC`, default 0: when 1, every slot-0 bit in LOCKED must carry `sync`. A missing sync is a framing error.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `din` input, 1: serial data bit for the current slot.
- `en` input, 1: `din`/`sync` qualifier; the bit is consumed only on edges where `en`=1.
- `sync` input, 1: frame-start marker, asserted together with the slot-0 bit; ignored when `en`=0.
- `d0`, `d1`, `d2`, `d3` output, 1 each: registered slot 0..3 bits of the last complete frame.
- `valid` output, 1: one-cycle strobe; `d0..d3` were updated at the same edge.
- `sel` output, 2: slot index the next accepted bit is written to.
- `locked` output, 1: high in LOCKED state.
- `err` output, 1: one-cycle framing-error strobe.

## Operation
- Reset (`rst`=1 at an edge, overrides all other inputs):
  - state=HUNT, `sel`=0, shadow slot registers=0.
  - `d0..d3`=0, `valid`=0, `err`=0, `locked`=0.
- HUNT:
  - Bits with `en`=1 and `sync`=0 are discarded; `sel` stays 0.
  - On `en`=1 and `sync`=1: `din` goes to shadow slot 0, `sel`<=1, state<=LOCKED.
- LOCKED, accepted bit (`en`=1):
  - `sel`=0: bit goes to shadow slot 0.
  - `sel`=1 or 2: bit goes to shadow slot `sel`.
  - `sel`=3: frame completes. `d0..d3` <= {shadow0, shadow1, shadow2, `din`} at this edge, and `valid`<=1.
  - `sel` increments modulo 4 on every accepted bit; 3 wraps to 0.
- LOCKED, `sync`=1 with `sel`!=0 (early sync):
  - `err`<=1 and the partial frame is discarded; `d0..d3` unchanged, no `valid`.
  - The bit is taken as slot 0 of a new frame, `sel`<=1, state stays LOCKED.
- LOCKED, `sync`=0 with `sel`=0:
  - `REQ_SYNC`=0: accepted normally as slot 0 (flywheel).
  - `REQ_SYNC`=1: `err`<=1, bit discarded, `sel`<=0, state<=HUNT, `locked`<=0.
- `en`=0: no state change. `sel` and shadow registers hold. `valid` and `err` drop to 0.
- `valid` and `err` are never both 1 in the same cycle.
- Shadow registers are internal. `d0..d3` change only on a completed frame or on reset.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Latency: the edge that samples the slot-3 bit loads `d0..d3` and sets `valid`=1. `valid` is 0 after the next edge.
- Back-to-back frames at full rate (`en`=1 every cycle): `valid` pulses every 4th cycle.
- `sel` reflects the slot for the bit presented in the current cycle, so the bench can predict routing combinationally.
- `err` goes high at the edge that samples the offending bit and lasts one cycle.
- HUNT->LOCKED takes effect at the edge that samples the sync bit. `locked`=1 from that edge.
- `rst` asserted mid-frame: partial frame lost, all outputs return to reset values at that edge. The next frame needs a new `sync`.

## Test plan
- Reset, then `en`=1 continuously with bits 1,0,1,1 and `sync` on the first bit. Required: `valid`=1 for exactly one cycle after the 4th edge, `d0`=1 `d1`=0 `d2`=1 `d3`=1, `locked`=1, `sel` sequence 0,1,2,3,0.
- Same frame with `en`=0 cycles inserted between slots (pattern 1,0,0,1,0,1,1 on `en`). Required: identical `d0..d3`, `valid` one cycle after the last accepted bit, `sel` holds during gaps.
- In HUNT, bits 1,1,1 with `sync`=0, then frame 0,1,1,0 with `sync` on the first bit. Required: the leading bits are ignored, the single `valid` has `d0..d3`=0,1,1,0.
- LOCKED, frame 1,1 then `sync`=1 on the third bit, followed by 0,0,1,0 (the sync bit is 0). Required: `err` pulse at the sync edge, no `valid` for the partial frame, then `valid` with `d0..d3`=0,0,1,0.
- `REQ_SYNC`=1: one good frame, then the next slot-0 bit arrives without `sync`. Required: `err` pulse, `locked`=0, `sel`=0, and no `valid` until a new sync frame completes.
- Assert `rst` one cycle while `sel`=2. Required: `d0..d3`=0, `valid`=0, `locked`=0, `sel`=0. A following sync frame 1,1,0,1 produces `d0..d3`=1,1,0,1.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a four-slot TDM serial link.
// Follows the frame-sync marker to track the slot index. Steers each
// accepted bit into its slot register. Publishes the reassembled 4-bit
// frame with a one-cycle valid strobe.
module tdm_demux4 #(
    parameter bit REQ_SYNC = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    input  logic       sync,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       valid,
    output logic [1:0] sel,
    output logic       locked,
    output logic       err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic [2:0] shadow_r, shadow_s;   // bit i holds slot i of the frame in progress
    logic [3:0] dout_r, dout_s;       // bit i drives d<i>
    logic       valid_r, valid_s;
    logic       err_r, err_s;
    logic       locked_r, locked_s;

    // Next-state, slot steering, frame completion and error detection
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        shadow_s = shadow_r;
        dout_s   = dout_r;
        valid_s  = 1'b0;
        err_s    = 1'b0;
        if (en) begin
            case (state_r)
                HUNT: begin
                    if (sync) begin
                        shadow_s[0] = din;
                        sel_s       = 2'd1;
                        state_s     = LOCKED;
                    end else begin
                        // Unframed bits are dropped while hunting
                        sel_s = 2'd0;
                    end
                end
                LOCKED: begin
                    if (sync && (sel_r != 2'd0)) begin
                        // Early sync: abandon the partial frame and restart at slot 0
                        err_s       = 1'b1;
                        shadow_s[0] = din;
                        sel_s       = 2'd1;
                    end else if (!sync && (sel_r == 2'd0) && (REQ_SYNC == 1'b1)) begin
                        // Missing sync where it is mandatory: drop the bit and re-hunt
                        err_s   = 1'b1;
                        sel_s   = 2'd0;
                        state_s = HUNT;
                    end else begin
                        case (sel_r)
                            2'd0: shadow_s[0] = din;
                            2'd1: shadow_s[1] = din;
                            2'd2: shadow_s[2] = din;
                            default: begin
                                // Slot 3 closes the frame
                                dout_s  = {din, shadow_r[2], shadow_r[1], shadow_r[0]};
                                valid_s = 1'b1;
                            end
                        endcase
                        sel_s = sel_r + 2'd1;
                    end
                end
                default: begin
                    state_s = HUNT;
                    sel_s   = 2'd0;
                end
            endcase
        end else begin
            // Idle cycle: everything holds, strobes fall back to 0
            state_s = state_r;
        end
        locked_s = (state_s == LOCKED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HUNT;
            sel_r    <= 2'd0;
            shadow_r <= 3'd0;
            dout_r   <= 4'd0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            shadow_r <= shadow_s;
            dout_r   <= dout_s;
            valid_r  <= valid_s;
            err_r    <= err_s;
            locked_r <= locked_s;
        end
    end

    assign d0     = dout_r[0];
    assign d1     = dout_r[1];
    assign d2     = dout_r[2];
    assign d3     = dout_r[3];
    assign valid  = valid_r;
    assign sel    = sel_r;
    assign locked = locked_r;
    assign err    = err_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, a REQ_SYNC=1 sequence,
// then random traffic against a frame-level reference model.
module tb_tdm_demux4;

    logic clk = 1'b0;
    logic rst = 1'b0, din = 1'b0, en = 1'b0, sync = 1'b0;
    logic a_d0, a_d1, a_d2, a_d3, a_valid, a_locked, a_err;
    logic b_d0, b_d1, b_d2, b_d3, b_valid, b_locked, b_err;
    logic [1:0] a_sel, b_sel;

    int nchk = 0;
    int nerr = 0;

    tdm_demux4 #(.REQ_SYNC(1'b0)) u0 (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
        .valid(a_valid), .sel(a_sel), .locked(a_locked), .err(a_err)
    );

    tdm_demux4 #(.REQ_SYNC(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
        .valid(b_valid), .sel(b_sel), .locked(b_locked), .err(b_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Packed observation: {d0,d1,d2,d3, valid, sel[1:0], locked, err}
    function automatic logic [8:0] obs0();
        return {a_d0, a_d1, a_d2, a_d3, a_valid, a_sel, a_locked, a_err};
    endfunction
    function automatic logic [8:0] obs1();
        return {b_d0, b_d1, b_d2, b_d3, b_valid, b_sel, b_locked, b_err};
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got d=%b v=%b sel=%0d lk=%b err=%b, want d=%b v=%b sel=%0d lk=%b err=%b",
                     name, act[8:5], act[4], act[3:2], act[1], act[0],
                     exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Frame-level reference model, one instance per REQ_SYNC setting.
    // A frame is a list of accepted bits; sel is simply how many are held.
    bit       m_lk  [2];
    int       m_cnt [2];
    bit       m_acc [2][4];
    bit [3:0] m_d   [2];
    bit       m_v   [2];
    bit       m_e   [2];

    task automatic model_step(input int m, input bit req, input bit r, input bit e,
                              input bit s, input bit dn);
        if (r) begin
            m_lk[m] = 1'b0; m_cnt[m] = 0; m_d[m] = 4'd0; m_v[m] = 1'b0; m_e[m] = 1'b0;
        end else begin
            m_v[m] = 1'b0;
            m_e[m] = 1'b0;
            if (e) begin
                if (!m_lk[m]) begin
                    if (s) begin
                        m_acc[m][0] = dn; m_cnt[m] = 1; m_lk[m] = 1'b1;
                    end
                end else if (s && m_cnt[m] != 0) begin
                    m_e[m] = 1'b1; m_acc[m][0] = dn; m_cnt[m] = 1;
                end else if (!s && m_cnt[m] == 0 && req) begin
                    m_e[m] = 1'b1; m_lk[m] = 1'b0;
                end else begin
                    m_acc[m][m_cnt[m]] = dn;
                    m_cnt[m] = m_cnt[m] + 1;
                    if (m_cnt[m] == 4) begin
                        m_d[m] = {m_acc[m][0], m_acc[m][1], m_acc[m][2], m_acc[m][3]};
                        m_v[m] = 1'b1;
                        m_cnt[m] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [8:0] mexp(input int m);
        logic [1:0] s2;
        s2 = m_cnt[m][1:0];
        return {m_d[m], m_v[m], s2, m_lk[m], m_e[m]};
    endfunction

    // Apply one cycle of inputs, clock it, advance both models
    task automatic step(input bit r, input bit e, input bit s, input bit dn);
        rst = r; en = e; sync = s; din = dn;
        @(posedge clk);
        #1;
        model_step(0, 1'b0, r, e, s, dn);
        model_step(1, 1'b1, r, e, s, dn);
    endtask

    typedef struct {
        bit       r, e, s, dn;
        bit [3:0] d;     // {d0,d1,d2,d3}
        bit       v;
        bit [1:0] sel;
        bit       l, er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit s, input bit dn,
                       input bit [3:0] d, input bit v, input bit [1:0] sl,
                       input bit l, input bit er);
        vec_t x;
        x.r = r; x.e = e; x.s = s; x.dn = dn;
        x.d = d; x.v = v; x.sel = sl; x.l = l; x.er = er;
        tbl.push_back(x);
    endtask

    initial begin
        // ---- directed table for REQ_SYNC=0 ----
        add(1,0,0,0, 4'b0000,0,2'd0,0,0);                                  // reset
        add(0,1,1,1, 4'b0000,0,2'd1,1,0); add(0,1,0,0, 4'b0000,0,2'd2,1,0); // frame 1,0,1,1
        add(0,1,0,1, 4'b0000,0,2'd3,1,0); add(0,1,0,1, 4'b1011,1,2'd0,1,0);
        add(0,0,0,0, 4'b1011,0,2'd0,1,0);
        add(1,0,0,0, 4'b0000,0,2'd0,0,0);                                  // gapped frame
        add(0,1,1,1, 4'b0000,0,2'd1,1,0); add(0,0,0,0, 4'b0000,0,2'd1,1,0);
        add(0,0,1,0, 4'b0000,0,2'd1,1,0); add(0,1,0,0, 4'b0000,0,2'd2,1,0);
        add(0,0,0,1, 4'b0000,0,2'd2,1,0); add(0,1,0,1, 4'b0000,0,2'd3,1,0);
        add(0,1,0,1, 4'b1011,1,2'd0,1,0); add(0,0,0,0, 4'b1011,0,2'd0,1,0);
        add(1,0,0,0, 4'b0000,0,2'd0,0,0);                                  // hunt discards
        add(0,1,0,1, 4'b0000,0,2'd0,0,0); add(0,1,0,1, 4'b0000,0,2'd0,0,0);
        add(0,1,0,1, 4'b0000,0,2'd0,0,0);
        add(0,1,1,0, 4'b0000,0,2'd1,1,0); add(0,1,0,1, 4'b0000,0,2'd2,1,0);
        add(0,1,0,1, 4'b0000,0,2'd3,1,0); add(0,1,0,0, 4'b0110,1,2'd0,1,0);
        add(0,0,0,0, 4'b0110,0,2'd0,1,0);
        add(0,1,1,1, 4'b0110,0,2'd1,1,0); add(0,1,0,1, 4'b0110,0,2'd2,1,0); // early sync
        add(0,1,1,0, 4'b0110,0,2'd1,1,1); add(0,1,0,0, 4'b0110,0,2'd2,1,0);
        add(0,1,0,1, 4'b0110,0,2'd3,1,0); add(0,1,0,0, 4'b0010,1,2'd0,1,0);
        add(0,0,0,0, 4'b0010,0,2'd0,1,0);
        add(0,1,1,1, 4'b0010,0,2'd1,1,0); add(0,1,0,1, 4'b0010,0,2'd2,1,0); // reset at sel=2
        add(1,1,1,1, 4'b0000,0,2'd0,0,0);
        add(0,1,1,1, 4'b0000,0,2'd1,1,0); add(0,1,0,1, 4'b0000,0,2'd2,1,0);
        add(0,1,0,0, 4'b0000,0,2'd3,1,0); add(0,1,0,1, 4'b1101,1,2'd0,1,0);
        add(0,1,0,0, 4'b1101,0,2'd1,1,0); add(0,1,0,0, 4'b1101,0,2'd2,1,0); // flywheel frame
        add(0,1,0,1, 4'b1101,0,2'd3,1,0); add(0,1,0,1, 4'b0011,1,2'd0,1,0);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].dn);
            chk($sformatf("vec%0d", i), obs0(),
                {tbl[i].d, tbl[i].v, tbl[i].sel, tbl[i].l, tbl[i].er});
        end

        // ---- REQ_SYNC=1: missing sync drops lock ----
        step(1,0,0,0); chk("rs_reset",   obs1(), {4'b0000,1'b0,2'd0,1'b0,1'b0});
        step(0,1,1,1); step(0,1,0,0); step(0,1,0,1); step(0,1,0,1);
        chk("rs_frame",   obs1(), {4'b1011,1'b1,2'd0,1'b1,1'b0});
        step(0,1,0,1); chk("rs_nosync",  obs1(), {4'b1011,1'b0,2'd0,1'b0,1'b1});
        step(0,1,0,1); chk("rs_hunt",    obs1(), {4'b1011,1'b0,2'd0,1'b0,1'b0});
        step(0,1,1,0); step(0,1,0,1); step(0,1,0,1);
        chk("rs_relock",  obs1(), {4'b1011,1'b0,2'd3,1'b1,1'b0});
        step(0,1,0,1); chk("rs_frame2",  obs1(), {4'b0111,1'b1,2'd0,1'b1,1'b0});

        // ---- random traffic against the reference model ----
        step(1,0,0,0);
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1);
            chk($sformatf("rnd0_%0d", k), obs0(), mexp(0));
            chk($sformatf("rnd1_%0d", k), obs1(), mexp(1));
            chk($sformatf("excl_%0d", k), {7'd0, a_valid & a_err, b_valid & b_err}, 9'd0);
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
